// File: rtl/proc_out_uart_tx.sv
// Output-port UART transmitter: 17-bit command word -> byte FIFO -> 8N1 line.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module proc_out_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [16:0] out_word_i,
    output logic [16:0] status_o,
    output logic        txd_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_txd;
    logic [16:0]   r_status;

    logic          w_strobe;
    logic          w_clr;
    logic          w_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_pop;
    logic          w_baud_end;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_par_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          w_txd_nxt;
    logic [16:0]   w_status_nxt;
    logic          w_unused_bits;

    assign w_unused_bits = ^out_word_i[14:8];

    assign w_strobe   = out_word_i[16];
    assign w_clr      = w_strobe & out_word_i[15];
    assign w_wr       = w_strobe & ~out_word_i[15];
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_empty    = (r_cnt == '0);
    assign w_push     = w_wr & ~w_full;
    assign w_ovf_set  = w_wr & w_full;
    assign w_baud_end = (r_baud == BAUD_MAX);

    // FIFO storage carries no reset; validity is tracked by r_cnt alone.
    always_ff @(posedge system1000) begin
        if (w_push) begin
            r_mem[r_wr] <= out_word_i[7:0];
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_state  <= S_IDLE;
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_txd    <= 1'b1;
            r_status <= 17'h00002;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_txd    <= w_txd_nxt;
            r_status <= w_status_nxt;
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_baud_nxt = r_baud + BW'(1);
        if ((r_state == S_IDLE) || w_baud_end) begin
            w_baud_nxt = '0;
        end

        w_bit_nxt = r_bit;
        if (r_state != S_DATA) begin
            w_bit_nxt = '0;
        end else if (w_baud_end) begin
            w_bit_nxt = r_bit + 3'd1;
        end

        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        if (w_pop) begin
            w_shift_nxt = r_mem[r_rd];
            w_par_nxt   = ^r_mem[r_rd];
        end else if ((r_state == S_DATA) && w_baud_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end
    end

    // Outputs are computed from next-state values so they land registered
    // in the same cycle the state changes.
    always_comb begin
        w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

        w_ovf_nxt = r_ovf;
        if (w_clr) begin
            w_ovf_nxt = 1'b0;
        end else if (w_ovf_set) begin
            w_ovf_nxt = 1'b1;
        end

        w_txd_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_nxt = w_par_nxt;
`endif
            default: w_txd_nxt = 1'b1;
        endcase

        w_status_nxt      = '0;
        w_status_nxt[0]   = (w_cnt_nxt == CNT_FULL);
        w_status_nxt[1]   = (w_cnt_nxt == '0);
        w_status_nxt[2]   = (w_state_nxt != S_IDLE) || (w_cnt_nxt != '0);
        w_status_nxt[3]   = w_ovf_nxt;
        w_status_nxt[7:4] = 4'(w_cnt_nxt);
    end

    assign txd_o    = r_txd;
    assign status_o = r_status;

endmodule
